// File: rtl/stepper_multi_axis_ctrl.sv
// stepper_multi_axis_ctrl: N_CH independent STEP/DIR pulse generators with
// direction setup, per-channel abort and a signed wrapping position counter.
module stepper_multi_axis_ctrl #(
   parameter int N_CH          = 2,
   parameter int STEP_W        = 32,
   parameter int POS_W         = 32,
   parameter int CNT_W         = 20,
   parameter int PERIOD_CYC    = 20000,
   parameter int HIGH_CYC      = 10000,
   parameter int DIR_SETUP_CYC = 100
) (
   input  logic                    i_Clk,
   input  logic                    i_rst,
   input  logic [N_CH-1:0]         i_cmd_valid,
   output logic [N_CH-1:0]         o_cmd_ready,
   input  logic [N_CH*STEP_W-1:0]  i_cmd_steps,
   input  logic [N_CH-1:0]         i_abort,
   input  logic [N_CH-1:0]         i_pos_clr,
   output logic [N_CH-1:0]         o_step,
   output logic [N_CH-1:0]         o_dir,
   output logic [N_CH-1:0]         o_busy,
   output logic [N_CH-1:0]         o_done,
   output logic [N_CH-1:0]         o_aborted,
   output logic [N_CH*POS_W-1:0]   o_pos
);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_END} state_t;
   localparam logic [CNT_W-1:0] SU_LAST = CNT_W'(DIR_SETUP_CYC > 0 ? DIR_SETUP_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(PERIOD_CYC - HIGH_CYC - 1);
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      state_t            r_state, w_nxt;
      logic [CNT_W-1:0]  r_cnt;
      logic [STEP_W-1:0] r_mag, r_n, w_steps, w_mag;
      logic [POS_W-1:0]  r_pos;
      logic              r_dir, r_abt, w_dir, w_abt, w_acc, w_run;
      logic              r_step, r_ready, r_busy, r_done, r_aborted;
      logic              w_step, w_ready, w_busy, w_done, w_aborted;
      assign w_steps = i_cmd_steps[k*STEP_W +: STEP_W];
      // unsigned negate maps the most negative command onto 2^(STEP_W-1)
      assign w_mag   = w_steps[STEP_W-1] ? ~w_steps + STEP_W'(1) : w_steps;
      assign w_acc   = (r_state == S_IDLE) && i_cmd_valid[k];
      assign w_run   = (r_state == S_SETUP) || (r_state == S_HIGH) || (r_state == S_LOW);
      assign w_abt   = r_abt || (w_run && i_abort[k]);
      assign w_dir   = w_acc ? !w_steps[STEP_W-1] : r_dir;
      always_comb begin
         w_nxt = r_state;
         case (r_state)
            S_IDLE:  if (i_cmd_valid[k]) w_nxt = (w_mag == '0) ? S_END : (DIR_SETUP_CYC == 0) ? S_HIGH : S_SETUP;
            S_SETUP: w_nxt = w_abt ? S_END : (r_cnt == SU_LAST) ? S_HIGH : S_SETUP;
            S_HIGH:  w_nxt = (r_cnt != HI_LAST) ? S_HIGH : w_abt ? S_END : S_LOW;
            S_LOW:   w_nxt = w_abt ? S_END : (r_cnt != LO_LAST) ? S_LOW : (r_n < r_mag) ? S_HIGH : S_END;
            default: w_nxt = S_IDLE;
         endcase
      end
      always_comb begin
         w_step    = w_nxt == S_HIGH;
         w_ready   = w_nxt == S_IDLE;
         w_busy    = w_nxt != S_IDLE;
         w_done    = (w_nxt == S_END) && !w_abt;
         w_aborted = (w_nxt == S_END) && w_abt;
      end
      always_ff @(posedge i_Clk) begin
         if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mag     <= '0;
            r_n       <= '0;
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_abt     <= 1'b0;
            r_step    <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
         end else begin
            r_state   <= w_nxt;
            r_cnt     <= (w_run && w_nxt == r_state) ? r_cnt + 1'b1 : '0;
            r_abt     <= w_run ? w_abt : 1'b0;
            r_dir     <= w_dir;
            r_step    <= w_step;
            r_ready   <= w_ready;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_aborted <= w_aborted;
            if (w_acc) begin
               r_mag <= w_mag;
               r_n   <= '0;
            end else if (r_state == S_HIGH && w_nxt != S_HIGH) begin
               r_n <= r_n + 1'b1;
            end
            if (i_pos_clr[k])
               r_pos <= '0;
            else if (w_nxt == S_HIGH && r_state != S_HIGH)
               r_pos <= w_dir ? r_pos + 1'b1 : r_pos - 1'b1;
         end
      end
      assign o_step[k]                  = r_step;
      assign o_dir[k]                   = r_dir;
      assign o_cmd_ready[k]             = r_ready;
      assign o_busy[k]                  = r_busy;
      assign o_done[k]                  = r_done;
      assign o_aborted[k]               = r_aborted;
      assign o_pos[k*POS_W +: POS_W]    = r_pos;
   end
endmodule

// File: tb/tb_stepper_multi_axis_ctrl.sv
// tb_stepper_multi_axis_ctrl: directed and random stimulus against a timeline
// model that predicts each channel's outputs from command/abort cycle arithmetic.
module tb_stepper_multi_axis_ctrl;
   localparam int N = 2, SW = 8, PW = 8, P = 10, H = 4, D = 2;
   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    valid = '0, abort = '0, pos_clr = '0;
   logic [N*SW-1:0] steps = '0;
   logic [N-1:0]    ready, step, dir, busy, done, aborted;
   logic [N*PW-1:0] pos;
   int n_chk = 0, n_err = 0, cyc = 0;
   int m_t0[N], m_mag[N], m_end[N];
   bit m_act[N], m_ab[N], m_dir[N];
   logic [PW-1:0] m_pos[N];

   stepper_multi_axis_ctrl #(
      .N_CH(N), .STEP_W(SW), .POS_W(PW), .CNT_W(8),
      .PERIOD_CYC(P), .HIGH_CYC(H), .DIR_SETUP_CYC(D)
   ) dut (
      .i_Clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
      .i_cmd_steps(steps), .i_abort(abort), .i_pos_clr(pos_clr),
      .o_step(step), .o_dir(dir), .o_busy(busy), .o_done(done),
      .o_aborted(aborted), .o_pos(pos)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // 0 idle, 1 setup, 2 high, 3 low, 4 end; k counts cycles since the command cycle
   function automatic int st(int ch, int c);
      int k, j;
      if (!m_act[ch]) return 0;
      k = c - m_t0[ch];
      if (k < 1 || k > m_end[ch]) return 0;
      if (k == m_end[ch]) return 4;
      if (k <= D) return 1;
      j = k - 1 - D;
      return (j % P < H) ? 2 : 3;
   endfunction

   task automatic model_edge;
      int cp, s;
      logic signed [SW-1:0] v;
      cp = cyc;
      cyc++;
      for (int ch = 0; ch < N; ch++) begin
         if (rst) begin
            m_act[ch] = 0;
            m_ab[ch]  = 0;
            m_dir[ch] = 0;
            m_pos[ch] = '0;
         end else begin
            s = st(ch, cp);
            if (s == 0 && valid[ch]) begin
               v = steps[ch*SW +: SW];
               m_act[ch] = 1;
               m_ab[ch]  = 0;
               m_t0[ch]  = cp;
               m_dir[ch] = (v >= 0);
               m_mag[ch] = (v < 0) ? -int'(v) : int'(v);
               m_end[ch] = (m_mag[ch] == 0) ? 1 : 1 + D + m_mag[ch] * P;
            end else if ((s == 1 || s == 3) && abort[ch] && !m_ab[ch]) begin
               m_ab[ch]  = 1;
               m_end[ch] = cyc - m_t0[ch];
            end else if (s == 2 && abort[ch] && !m_ab[ch]) begin
               m_ab[ch]  = 1;
               m_end[ch] = 1 + D + ((cp - m_t0[ch] - 1 - D) / P) * P + H;
            end
            if (pos_clr[ch])
               m_pos[ch] = '0;
            else if (st(ch, cyc) == 2 && st(ch, cp) != 2)
               m_pos[ch] = m_dir[ch] ? m_pos[ch] + 1'b1 : m_pos[ch] - 1'b1;
         end
      end
   endtask

   task automatic compare;
      int s;
      for (int ch = 0; ch < N; ch++) begin
         s = st(ch, cyc);
         check($sformatf("ch%0d_outputs", ch),
               {18'd0, step[ch], dir[ch], busy[ch], ready[ch], done[ch], aborted[ch], pos[ch*PW +: PW]},
               {18'd0, s == 2, m_dir[ch], s != 0, s == 0, s == 4 && !m_ab[ch], s == 4 && m_ab[ch], m_pos[ch]});
      end
   endtask

   task automatic tick;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic wait_idle(input int ch);
      for (int i = 0; i < 2000 && !ready[ch]; i++) tick();
      check("idle_wait", {31'd0, ready[ch]}, 32'd1);
   endtask

   task automatic cmd(input int ch, input int n, input bit clr);
      valid[ch] = 1'b1;
      pos_clr[ch] = clr;
      steps[ch*SW +: SW] = SW'(n);
      tick();
      valid[ch] = 1'b0;
      pos_clr[ch] = 1'b0;
   endtask

   initial begin
      int t0;
      @(negedge clk);
      tick();
      tick();
      check("reset_ready", {30'd0, ready}, 32'd3);
      check("reset_busy", {30'd0, busy | step | done | aborted | dir}, 32'd0);
      rst = 1'b0;
      tick();
      // +3 on ch0, -2 on ch1 overlapping it
      t0 = cyc;
      cmd(0, 3, 1'b1);
      check("dir0_t1", {31'd0, dir[0]}, 32'd1);
      while (cyc < t0 + 5) tick();
      cmd(1, -2, 1'b1);
      while (cyc < t0 + 33) tick();
      check("done0_t33", {31'd0, done[0]}, 32'd1);
      wait_idle(0);
      wait_idle(1);
      check("pos0_plus3", {24'd0, pos[0 +: PW]}, 32'd3);
      check("pos1_minus2", {24'd0, pos[PW +: PW]}, 32'hFE);
      // zero-length command
      cmd(0, 0, 1'b0);
      check("zero_done", {30'd0, done[0], step[0]}, 32'd2);
      tick();
      check("zero_ready", {31'd0, ready[0]}, 32'd1);
      check("zero_pos", {24'd0, pos[0 +: PW]}, 32'd3);
      // abort during the second high phase
      t0 = cyc;
      cmd(0, 5, 1'b1);
      while (cyc < t0 + 14) tick();
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      while (cyc < t0 + 16) tick();
      check("abort_high_kept", {31'd0, step[0]}, 32'd1);
      while (cyc < t0 + 17) tick();
      check("abort_pulse", {30'd0, aborted[0], done[0]}, 32'd2);
      wait_idle(0);
      check("abort_pos", {24'd0, pos[0 +: PW]}, 32'd2);
      // most negative command with narrow position counter
      cmd(1, -128, 1'b1);
      check("neg128_dir", {31'd0, dir[1]}, 32'd0);
      wait_idle(1);
      check("neg128_pos", {24'd0, pos[PW +: PW]}, 32'h80);
      // clear coinciding with a step entry
      t0 = cyc;
      cmd(0, 2, 1'b1);
      while (cyc < t0 + 2) tick();
      pos_clr[0] = 1'b1;
      tick();
      pos_clr[0] = 1'b0;
      check("clr_wins", {23'd0, step[0], pos[0 +: PW]}, 32'h100);
      wait_idle(0);
      check("clr_final", {24'd0, pos[0 +: PW]}, 32'd1);
      // reset while STEP is high
      t0 = cyc;
      cmd(0, 3, 1'b0);
      while (cyc < t0 + 3) tick();
      check("pre_reset_step", {31'd0, step[0]}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("reset_mid", {22'd0, step[0], busy[0], ready[0], pos[0 +: PW]}, 32'h100);
      cmd(0, 1, 1'b0);
      wait_idle(0);
      check("post_reset_pos", {24'd0, pos[0 +: PW]}, 32'd1);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < N; ch++) begin
            valid[ch]   = ($urandom_range(0, 7) == 0);
            steps[ch*SW +: SW] = SW'($urandom_range(0, 12)) - SW'(6);
            abort[ch]   = ($urandom_range(0, 39) == 0);
            pos_clr[ch] = ($urandom_range(0, 59) == 0);
         end
         tick();
      end
      valid = '0;
      abort = '0;
      pos_clr = '0;
      wait_idle(0);
      wait_idle(1);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
